// File: rtl/fir_pkg.sv
// Shared definitions for the band FIR sequencing controllers: sample width,
// default tap count, FSM state encoding and a counter sizing helper.
package fir_pkg;

  localparam int SAMPLE_W       = 16;
  localparam int N_TAPS_DEFAULT = 1021;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    RUN     = 2'd1,
    SETTLE  = 2'd2,
    CAPTURE = 2'd3
  } fir_state_e;

  // Bits needed to hold max_val, never fewer than 3 so the settle load
  // (at most 5) always fits.
  function automatic int cnt_width(input int max_val);
    int w;
    w = 1;
    for (int i = 1; i < 32; i++) begin
      if ((1 << w) <= max_val) w = w + 1;
    end
    return (w < 3) ? 3 : w;
  endfunction

endpackage

// File: rtl/fir_seq_ctrl_if.sv
// Sample/result bus between the audio source, the FIR datapath and the
// sequencing controller. The controller is the slave side.
interface fir_seq_ctrl_if;
  import fir_pkg::*;

  logic                       smpl_vld;
  logic signed [SAMPLE_W-1:0] lft_in;
  logic signed [SAMPLE_W-1:0] rht_in;
  logic signed [SAMPLE_W-1:0] filtered_L;
  logic signed [SAMPLE_W-1:0] filtered_R;
  logic                       sequencing;
  logic signed [SAMPLE_W-1:0] lft_to_fir;
  logic signed [SAMPLE_W-1:0] rht_to_fir;
  logic signed [SAMPLE_W-1:0] lft_out;
  logic signed [SAMPLE_W-1:0] rht_out;
  logic                       out_vld;
  logic                       busy;
  logic                       overrun;

  modport master (
    output smpl_vld, lft_in, rht_in, filtered_L, filtered_R,
    input  sequencing, lft_to_fir, rht_to_fir, lft_out, rht_out,
           out_vld, busy, overrun
  );

  modport slave (
    input  smpl_vld, lft_in, rht_in, filtered_L, filtered_R,
    output sequencing, lft_to_fir, rht_to_fir, lft_out, rht_out,
           out_vld, busy, overrun
  );

endinterface

// File: rtl/fir_seq_ctrl_seq_cnt.sv
// Loadable down-counter that stops at zero; tc_o flags the zero count and
// marks the last cycle of a RUN or SETTLE interval.
module seq_cnt #(
  parameter int W = 10
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         load_i,
  input  logic [W-1:0] load_val_i,
  output logic         tc_o
);

  logic [W-1:0] count_q;
  logic [W-1:0] count_d;

  // Load wins over counting; the count parks at zero instead of wrapping.
  always_comb begin
    count_d = count_q;
    if (load_i) begin
      count_d = load_val_i;
    end else if (count_q != '0) begin
      count_d = count_q - W'(1);
    end
  end

  // Count register.
  always_ff @(posedge clk) begin
    if (rst) count_q <= '0;
    else     count_q <= count_d;
  end

  assign tc_o = (count_q == '0);

endmodule

// File: rtl/fir_seq_ctrl.sv
// FIR run sequencer: latches a stereo sample, enables the datapath for
// N_TAPS+PIPE_LAT cycles, waits SETTLE_CYC cycles with the enable low, then
// captures the filter results with a one-cycle out_vld strobe.
// Optional FIR_SEQ_SKID_EN: one-entry skid buffer for a sample arriving
// while busy; without it every busy-time sample is dropped as an overrun.
module fir_seq_ctrl
  import fir_pkg::*;
#(
  parameter int N_TAPS     = N_TAPS_DEFAULT,
  parameter int PIPE_LAT   = 1,
  parameter int SETTLE_CYC = 2
) (
  input logic           clk,
  input logic           rst,
  fir_seq_ctrl_if.slave bus
);

  localparam int RUN_LEN = N_TAPS + PIPE_LAT;
  localparam int CNT_W   = cnt_width(RUN_LEN);
  // SETTLE plus the single CAPTURE cycle together last SETTLE_CYC cycles,
  // so SETTLE itself is skipped entirely when SETTLE_CYC is 1.
  localparam bit              HAS_SETTLE  = (SETTLE_CYC > 1);
  localparam logic [CNT_W-1:0] RUN_LOAD    = CNT_W'(RUN_LEN - 1);
  localparam logic [CNT_W-1:0] SETTLE_LOAD = CNT_W'(HAS_SETTLE ? SETTLE_CYC - 2 : 0);

  fir_state_e          state_q;
  logic                seq_q, busy_q, vld_q, ovr_q;
  logic [SAMPLE_W-1:0] to_l_q, to_r_q, out_l_q, out_r_q;

  logic                start;
  logic [SAMPLE_W-1:0] start_l, start_r;
  logic                load_en;
  logic [CNT_W-1:0]    load_val;
  logic                cnt_tc;

`ifdef FIR_SEQ_SKID_EN
  logic                skid_vld_q;
  logic [SAMPLE_W-1:0] skid_l_q, skid_r_q;
`endif

  // Pick the sample that starts the next run (held sample first) and decide
  // when the interval counter is reloaded.
  always_comb begin
    start   = 1'b0;
    start_l = bus.lft_in;
    start_r = bus.rht_in;
    if (state_q == IDLE) begin
`ifdef FIR_SEQ_SKID_EN
      if (skid_vld_q) begin
        start   = 1'b1;
        start_l = skid_l_q;
        start_r = skid_r_q;
      end else begin
        start = bus.smpl_vld;
      end
`else
      start = bus.smpl_vld;
`endif
    end
    load_en  = start || ((state_q == RUN) && cnt_tc && HAS_SETTLE);
    load_val = start ? RUN_LOAD : SETTLE_LOAD;
  end

  seq_cnt #(.W(CNT_W)) u_seq_cnt (
    .clk        (clk),
    .rst        (rst),
    .load_i     (load_en),
    .load_val_i (load_val),
    .tc_o       (cnt_tc)
  );

  // Run-sequencing FSM with registered outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      seq_q   <= 1'b0;
      busy_q  <= 1'b0;
      vld_q   <= 1'b0;
      to_l_q  <= '0;
      to_r_q  <= '0;
      out_l_q <= '0;
      out_r_q <= '0;
    end else begin
      vld_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (start) begin
            state_q <= RUN;
            seq_q   <= 1'b1;
            busy_q  <= 1'b1;
            to_l_q  <= start_l;
            to_r_q  <= start_r;
          end
        end
        RUN: begin
          if (cnt_tc) begin
            seq_q <= 1'b0;
            if (HAS_SETTLE) state_q <= SETTLE;
            else            state_q <= CAPTURE;
          end
        end
        SETTLE: begin
          if (cnt_tc) state_q <= CAPTURE;
        end
        CAPTURE: begin
          out_l_q <= bus.filtered_L;
          out_r_q <= bus.filtered_R;
          vld_q   <= 1'b1;
          busy_q  <= 1'b0;
          state_q <= IDLE;
        end
        default: begin
          state_q <= IDLE;
          seq_q   <= 1'b0;
          busy_q  <= 1'b0;
        end
      endcase
    end
  end

  // Handle samples arriving while a run is in flight: hold one if there is
  // room, otherwise drop it and raise the sticky overrun flag.
  always_ff @(posedge clk) begin
    if (rst) begin
      ovr_q <= 1'b0;
`ifdef FIR_SEQ_SKID_EN
      skid_vld_q <= 1'b0;
      skid_l_q   <= '0;
      skid_r_q   <= '0;
`endif
    end else begin
`ifdef FIR_SEQ_SKID_EN
      if (state_q == IDLE) begin
        if (skid_vld_q) begin
          skid_vld_q <= bus.smpl_vld;
          if (bus.smpl_vld) begin
            skid_l_q <= bus.lft_in;
            skid_r_q <= bus.rht_in;
          end
        end
      end else if (bus.smpl_vld) begin
        if (!skid_vld_q) begin
          skid_vld_q <= 1'b1;
          skid_l_q   <= bus.lft_in;
          skid_r_q   <= bus.rht_in;
        end else begin
          ovr_q <= 1'b1;
        end
      end
`else
      if ((state_q != IDLE) && bus.smpl_vld) ovr_q <= 1'b1;
`endif
    end
  end

  assign bus.sequencing = seq_q;
  assign bus.busy       = busy_q;
  assign bus.out_vld    = vld_q;
  assign bus.overrun    = ovr_q;
  assign bus.lft_to_fir = to_l_q;
  assign bus.rht_to_fir = to_r_q;
  assign bus.lft_out    = out_l_q;
  assign bus.rht_out    = out_r_q;

endmodule

// File: tb/tb_fir_seq_ctrl.sv
// Self-checking bench for fir_seq_ctrl with N_TAPS=4, PIPE_LAT=1,
// SETTLE_CYC=2. A timeline model derives every expected output from the
// acceptance cycle of the current run; directed scenarios pin key cycles.
module tb_fir_seq_ctrl;

  localparam int L = 5;
  localparam int S = 2;
`ifdef FIR_SEQ_SKID_EN
  localparam bit SKID = 1'b1;
`else
  localparam bit SKID = 1'b0;
`endif

  logic clk;
  logic rst;
  fir_seq_ctrl_if busIf ();

  fir_seq_ctrl #(.N_TAPS(4), .PIPE_LAT(1), .SETTLE_CYC(2)) dut (
    .clk (clk),
    .rst (rst),
    .bus (busIf)
  );

  int checks   = 0;
  int failures = 0;
  int cyc      = 0;
  int base     = 0;
  int p0 = -1, p1 = -1, p2 = -1;
  bit pulsesOn = 1'b0;
  bit modelValid = 1'b0;

  // model expectations for the current cycle
  logic        expSeq, expBusy, expVld, expOvr;
  logic [15:0] expToL, expToR, expOutL, expOutR;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #200000;
    $display("[TB] FAIL watchdog actual=timeout required=finish");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic checkOutput(input string name, input logic [15:0] act,
                             input logic [15:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("[TB] FAIL %s at cycle %0d: actual=%h required=%h",
               name, cyc - base, act, exp);
    end
  endtask

  // Input driver: pulses at scheduled relative cycles, changing data every cycle
  initial begin
    int rel;
    busIf.smpl_vld   = 1'b0;
    busIf.lft_in     = '0;
    busIf.rht_in     = '0;
    busIf.filtered_L = '0;
    busIf.filtered_R = '0;
    forever begin
      @(posedge clk);
      #2;
      rel = cyc - base;
      busIf.smpl_vld   = pulsesOn && (rel == p0 || rel == p1 || rel == p2);
      busIf.lft_in     = (rel == 10) ? 16'h1234 : 16'h0100 + 16'(rel);
      busIf.rht_in     = ~busIf.lft_in;
      busIf.filtered_L = 16'hA000 + 16'(rel);
      busIf.filtered_R = 16'h5000 + 16'(3 * rel);
    end
  end

  // Timeline model: a run accepted in cycle t is busy in t+1..t+L+S,
  // sequences in t+1..t+L, captures filtered values of t+L+S, and strobes
  // out_vld in t+L+S+1 (which is already an idle cycle).
  initial begin
    bit runValid;
    int runAcc;
    bit skidFull;
    logic [15:0] skidL, skidR;
    bit idle;
    int c, n;
    runValid = 0; runAcc = 0; skidFull = 0; skidL = 0; skidR = 0;
    forever begin
      @(posedge clk);
      c = cyc;
      if (rst) begin
        runValid = 0; skidFull = 0;
        expOvr = 0; expVld = 0;
        expToL = 0; expToR = 0; expOutL = 0; expOutR = 0;
        modelValid = 1'b1;
      end else begin
        idle   = !runValid || (c > runAcc + L + S);
        expVld = 1'b0;
        if (runValid && c == runAcc + L + S) begin
          expOutL = busIf.filtered_L;
          expOutR = busIf.filtered_R;
          expVld  = 1'b1;
        end
        if (idle) begin
          if (SKID && skidFull) begin
            runValid = 1; runAcc = c;
            expToL = skidL; expToR = skidR;
            skidFull = 0;
            if (busIf.smpl_vld) begin
              skidFull = 1; skidL = busIf.lft_in; skidR = busIf.rht_in;
            end
          end else if (busIf.smpl_vld) begin
            runValid = 1; runAcc = c;
            expToL = busIf.lft_in; expToR = busIf.rht_in;
          end
        end else if (busIf.smpl_vld) begin
          if (SKID && !skidFull) begin
            skidFull = 1; skidL = busIf.lft_in; skidR = busIf.rht_in;
          end else begin
            expOvr = 1'b1;
          end
        end
      end
      n = c + 1;
      expSeq  = runValid && (n >= runAcc + 1) && (n <= runAcc + L);
      expBusy = runValid && (n >= runAcc + 1) && (n <= runAcc + L + S);
    end
  end

  // Every-cycle comparison of all outputs against the model
  always @(negedge clk) begin
    if (modelValid) begin
      checkOutput("sequencing", 16'(busIf.sequencing), 16'(expSeq));
      checkOutput("busy",       16'(busIf.busy),       16'(expBusy));
      checkOutput("out_vld",    16'(busIf.out_vld),    16'(expVld));
      checkOutput("overrun",    16'(busIf.overrun),    16'(expOvr));
      checkOutput("lft_to_fir", busIf.lft_to_fir, expToL);
      checkOutput("rht_to_fir", busIf.rht_to_fir, expToR);
      checkOutput("lft_out",    busIf.lft_out,    expOutL);
      checkOutput("rht_out",    busIf.rht_out,    expOutR);
    end
  end

  // Reset, then schedule smpl_vld pulses at relative cycles (cycle 0 is the
  // first cycle with rst low).
  task automatic applyStimulus(input int a, input int b, input int c);
    pulsesOn = 1'b0;
    rst = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    rst  = 1'b0;
    base = cyc;
    p0 = a; p1 = b; p2 = c;
    pulsesOn = 1'b1;
  endtask

  task automatic atCycle(input int k);
    while (cyc < base + k) begin
      @(posedge clk);
      #1;
    end
    @(negedge clk);
  endtask

  task automatic pulseResetAt(input int k);
    while (cyc < base + k) begin
      @(posedge clk);
      #1;
    end
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
  endtask

  initial begin
    rst = 1'b1;

    // single sample
    applyStimulus(10, -1, -1);
    atCycle(0);
    checkOutput("s1 reset busy", 16'(busIf.busy), 16'h0);
    checkOutput("s1 reset lft_out", busIf.lft_out, 16'h0000);
    atCycle(10);
    checkOutput("s1 c10 seq", 16'(busIf.sequencing), 16'h0);
    atCycle(11);
    checkOutput("s1 c11 seq", 16'(busIf.sequencing), 16'h1);
    checkOutput("s1 c11 lft_to_fir", busIf.lft_to_fir, 16'h1234);
    checkOutput("s1 c11 rht_to_fir", busIf.rht_to_fir, 16'hEDCB);
    atCycle(15);
    checkOutput("s1 c15 seq", 16'(busIf.sequencing), 16'h1);
    atCycle(16);
    checkOutput("s1 c16 seq", 16'(busIf.sequencing), 16'h0);
    checkOutput("s1 c16 busy", 16'(busIf.busy), 16'h1);
    atCycle(17);
    checkOutput("s1 c17 out_vld", 16'(busIf.out_vld), 16'h0);
    atCycle(18);
    checkOutput("s1 c18 out_vld", 16'(busIf.out_vld), 16'h1);
    checkOutput("s1 c18 lft_out", busIf.lft_out, 16'hA011);
    checkOutput("s1 c18 rht_out", busIf.rht_out, 16'h5033);
    checkOutput("s1 c18 busy", 16'(busIf.busy), 16'h0);
    atCycle(19);
    checkOutput("s1 c19 out_vld", 16'(busIf.out_vld), 16'h0);
    checkOutput("s1 c19 lft_out hold", busIf.lft_out, 16'hA011);
    atCycle(30);

    // back-to-back, second sample coincident with out_vld
    applyStimulus(10, 18, -1);
    atCycle(18);
    checkOutput("s2 c18 out_vld", 16'(busIf.out_vld), 16'h1);
    atCycle(19);
    checkOutput("s2 c19 seq", 16'(busIf.sequencing), 16'h1);
    checkOutput("s2 c19 lft_to_fir", busIf.lft_to_fir, 16'h0112);
    atCycle(26);
    checkOutput("s2 c26 out_vld", 16'(busIf.out_vld), 16'h1);
    checkOutput("s2 c26 lft_out", busIf.lft_out, 16'hA019);
    checkOutput("s2 c26 rht_out", busIf.rht_out, 16'h504B);
    checkOutput("s2 c26 overrun", 16'(busIf.overrun), 16'h0);
    atCycle(30);

    // sample while busy
    applyStimulus(10, 13, -1);
    atCycle(13);
    checkOutput("s3 c13 overrun", 16'(busIf.overrun), 16'h0);
`ifdef FIR_SEQ_SKID_EN
    atCycle(14);
    checkOutput("s3 c14 overrun", 16'(busIf.overrun), 16'h0);
    atCycle(19);
    checkOutput("s3 c19 seq", 16'(busIf.sequencing), 16'h1);
    checkOutput("s3 c19 lft_to_fir", busIf.lft_to_fir, 16'h010D);
    checkOutput("s3 c19 rht_to_fir", busIf.rht_to_fir, 16'hFEF2);
    atCycle(26);
    checkOutput("s3 c26 out_vld", 16'(busIf.out_vld), 16'h1);
    checkOutput("s3 c26 overrun", 16'(busIf.overrun), 16'h0);
`else
    atCycle(14);
    checkOutput("s3 c14 overrun", 16'(busIf.overrun), 16'h1);
    atCycle(19);
    checkOutput("s3 c19 seq", 16'(busIf.sequencing), 16'h0);
    checkOutput("s3 c19 lft_to_fir", busIf.lft_to_fir, 16'h1234);
    atCycle(26);
    checkOutput("s3 c26 out_vld", 16'(busIf.out_vld), 16'h0);
    checkOutput("s3 c26 overrun", 16'(busIf.overrun), 16'h1);
`endif
    atCycle(32);

    // skid full / repeated drops
    applyStimulus(10, 12, 14);
`ifdef FIR_SEQ_SKID_EN
    atCycle(15);
    checkOutput("s4 c15 overrun", 16'(busIf.overrun), 16'h1);
    atCycle(19);
    checkOutput("s4 c19 seq", 16'(busIf.sequencing), 16'h1);
    checkOutput("s4 c19 lft_to_fir", busIf.lft_to_fir, 16'h010C);
    atCycle(26);
    checkOutput("s4 c26 out_vld", 16'(busIf.out_vld), 16'h1);
    atCycle(27);
    checkOutput("s4 c27 seq", 16'(busIf.sequencing), 16'h0);
    checkOutput("s4 c27 busy", 16'(busIf.busy), 16'h0);
`else
    atCycle(13);
    checkOutput("s4 c13 overrun", 16'(busIf.overrun), 16'h1);
    atCycle(19);
    checkOutput("s4 c19 seq", 16'(busIf.sequencing), 16'h0);
`endif
    atCycle(32);

    // reset mid-run, then a clean run
    applyStimulus(10, 20, -1);
    pulseResetAt(13);
    atCycle(14);
    checkOutput("s5 c14 seq", 16'(busIf.sequencing), 16'h0);
    checkOutput("s5 c14 busy", 16'(busIf.busy), 16'h0);
    checkOutput("s5 c14 lft_to_fir", busIf.lft_to_fir, 16'h0000);
    checkOutput("s5 c14 rht_to_fir", busIf.rht_to_fir, 16'h0000);
    checkOutput("s5 c14 lft_out", busIf.lft_out, 16'h0000);
    checkOutput("s5 c14 overrun", 16'(busIf.overrun), 16'h0);
    atCycle(18);
    checkOutput("s5 c18 out_vld", 16'(busIf.out_vld), 16'h0);
    atCycle(21);
    checkOutput("s5 c21 seq", 16'(busIf.sequencing), 16'h1);
    checkOutput("s5 c21 lft_to_fir", busIf.lft_to_fir, 16'h0114);
    atCycle(28);
    checkOutput("s5 c28 out_vld", 16'(busIf.out_vld), 16'h1);
    checkOutput("s5 c28 lft_out", busIf.lft_out, 16'hA01B);
    checkOutput("s5 c28 rht_out", busIf.rht_out, 16'h5051);
    atCycle(32);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
